// File: rtl/alu_pkg.sv
// Shared types for the ALU op sequencer: operand width, ALU opcodes and sequencer FSM states.
package alu_pkg;

  parameter int unsigned BITS = 8;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU-side signal bundle for the ALU op sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned BITS = 8
) ();

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [BITS-1:0] req_a;
  logic [BITS-1:0] req_b;
  logic            req_chain;
  logic            req_clr;

  logic [BITS-1:0] alu_a;
  logic [BITS-1:0] alu_b;
  logic [1:0]      alu_f;
  logic [BITS-1:0] alu_result;
  logic            alu_flag;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_result;
  logic            rsp_flag;

  // Environment side: issues requests, consumes responses, hosts the ALU.
  modport master (
    output req_valid, req_op, req_a, req_b, req_chain, req_clr,
    output rsp_ready, alu_result, alu_flag,
    input  req_ready, alu_a, alu_b, alu_f, rsp_valid, rsp_result, rsp_flag
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_chain, req_clr,
    input  rsp_ready, alu_result, alu_flag,
    output req_ready, alu_a, alu_b, alu_f, rsp_valid, rsp_result, rsp_flag
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator-side controller for the 8-bit ALU: registers operands/opcode, captures result and
// flag one cycle later, returns them on a valid/ready response, and tracks acc / overflow count.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_op_sequencer_if.slave bus,
  output logic [BITS-1:0]  acc,
  output logic [CNT_W-1:0] ovf_count
);

  seq_state_t      state_q, state_d;
  logic [BITS-1:0] alu_a_q, alu_b_q;
  logic [1:0]      alu_f_q;
  logic [BITS-1:0] rsp_result_q;
  logic            rsp_flag_q;
  logic [BITS-1:0] acc_q;
  logic            accept;
  logic            clr_req;
  logic            in_exec;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    clr_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // A clear request never issues an ALU op, whatever opcode rides along.
          if (bus.req_clr) begin
            clr_req = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = EXEC;
          end
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_exec = (state_q == EXEC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_f_q      <= 2'b00;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      acc_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q <= bus.req_chain ? acc_q : bus.req_a;
        alu_b_q <= bus.req_b;
        alu_f_q <= bus.req_op;
      end
      if (in_exec) begin
        rsp_result_q <= bus.alu_result;
        rsp_flag_q   <= bus.alu_flag;
        acc_q        <= bus.alu_result;
      end
      if (clr_req) begin
        acc_q <= '0;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_ovf_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_req),
    .inc   (in_exec && bus.alu_flag),
    .count (ovf_count)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_f      = alu_f_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flag   = rsp_flag_q;
  assign acc            = acc_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural 8-bit signed ALU.
module tb_alu_op_sequencer;

  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             reset;
  logic [7:0]       acc;
  logic [CNT_W-1:0] ovf_count;
  logic [7:0]       alu_r;
  int               checks;
  int               errors;

  alu_op_sequencer_if #(.BITS(8)) bus ();

  alu_op_sequencer #(
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .acc       (acc),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: signed overflow on ADD/SUB, flag always 0 for logic ops.
  always_comb begin
    alu_r = 8'h00;
    bus.alu_flag = 1'b0;
    case (bus.alu_f)
      2'b00: alu_r = bus.alu_a & bus.alu_b;
      2'b01: alu_r = bus.alu_a | bus.alu_b;
      2'b10: begin
        alu_r = bus.alu_a + bus.alu_b;
        bus.alu_flag = (bus.alu_a[7] == bus.alu_b[7]) && (alu_r[7] != bus.alu_a[7]);
      end
      default: begin
        alu_r = bus.alu_a - bus.alu_b;
        bus.alu_flag = (bus.alu_a[7] != bus.alu_b[7]) && (alu_r[7] != bus.alu_a[7]);
      end
    endcase
    bus.alu_result = alu_r;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a request for one cycle; returns at the negedge after acceptance (EXEC).
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic chain);
    @(negedge clk);
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_chain = chain; bus.req_clr = 1'b0;
    bus.req_valid = 1'b1;
    check("issue_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_chain = 1'b0;
    check("exec_no_rsp", 32'(bus.rsp_valid), 32'h0);
    check("exec_busy", 32'(bus.req_ready), 32'h0);
  endtask

  // Checks the response one cycle after EXEC, completes the handshake and checks IDLE return.
  task automatic expect_rsp(input string tag, input logic [7:0] res, input logic flag,
                            input logic [31:0] ovf);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'h1);
    check({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
    check({tag, "_flag"}, 32'(bus.rsp_flag), 32'(flag));
    check({tag, "_acc"}, 32'(acc), 32'(res));
    check({tag, "_ovf"}, 32'(ovf_count), ovf);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_done"}, 32'(bus.rsp_valid), 32'h0);
    check({tag, "_idle"}, 32'(bus.req_ready), 32'h1);
  endtask

  task automatic clear_req();
    @(negedge clk);
    bus.req_op = 2'b10; bus.req_a = 8'h55; bus.req_b = 8'h55; bus.req_clr = 1'b1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_clr = 1'b0;
    check("clr_acc", 32'(acc), 32'h0);
    check("clr_ovf", 32'(ovf_count), 32'h0);
    check("clr_ready", 32'(bus.req_ready), 32'h1);
    check("clr_no_rsp", 32'(bus.rsp_valid), 32'h0);
    @(negedge clk);
    check("clr_no_rsp2", 32'(bus.rsp_valid), 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_a = 8'h00; bus.req_b = 8'h00;
    bus.req_chain = 1'b0; bus.req_clr = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'h1);
    check("rst_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_result", 32'(bus.rsp_result), 32'h0);
    check("rst_flag", 32'(bus.rsp_flag), 32'h0);
    check("rst_acc", 32'(acc), 32'h0);
    check("rst_ovf", 32'(ovf_count), 32'h0);
    check("rst_alu_a", 32'(bus.alu_a), 32'h0);
    check("rst_alu_b", 32'(bus.alu_b), 32'h0);
    check("rst_alu_f", 32'(bus.alu_f), 32'h0);
    reset = 1'b0;

    // 127 + 1 overflows to -128.
    issue(2'b10, 8'h7F, 8'h01, 1'b0);
    check("add_alu_f", 32'(bus.alu_f), 32'h2);
    expect_rsp("add_ovf", 8'h80, 1'b1, 32'h1);

    // -128 - 1 underflows to 127, then chained +1 overflows from acc.
    clear_req();
    issue(2'b11, 8'h80, 8'h01, 1'b0);
    expect_rsp("sub_unf", 8'h7F, 1'b1, 32'h1);
    issue(2'b10, 8'h00, 8'h01, 1'b1);
    check("chain_alu_a", 32'(bus.alu_a), 32'h7F);
    expect_rsp("chain_add", 8'h80, 1'b1, 32'h2);

    // Non-overflowing cases leave the counter alone.
    issue(2'b11, 8'h7F, 8'h01, 1'b0);
    expect_rsp("sub_ok", 8'h7E, 1'b0, 32'h2);
    issue(2'b10, 8'h80, 8'h01, 1'b0);
    expect_rsp("add_ok", 8'h81, 1'b0, 32'h2);
    issue(2'b00, 8'hF0, 8'h3C, 1'b0);
    expect_rsp("and", 8'h30, 1'b0, 32'h2);
    issue(2'b01, 8'hF0, 8'h3C, 1'b0);
    expect_rsp("or", 8'hFC, 1'b0, 32'h2);

    // Back-pressure with a pending request waiting behind the response.
    issue(2'b10, 8'h05, 8'h03, 1'b0);
    bus.req_op = 2'b10; bus.req_a = 8'h01; bus.req_b = 8'h01; bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_result", 32'(bus.rsp_result), 32'h08);
      check("bp_flag", 32'(bus.rsp_flag), 32'h0);
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      check("bp_alu_a", 32'(bus.alu_a), 32'h05);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("bp_done", 32'(bus.rsp_valid), 32'h0);
    check("bp_idle", 32'(bus.req_ready), 32'h1);
    check("bp_not_taken", 32'(bus.alu_a), 32'h05);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("bp_taken", 32'(bus.alu_a), 32'h01);
    check("bp_taken_busy", 32'(bus.req_ready), 32'h0);
    expect_rsp("bp_next", 8'h02, 1'b0, 32'h2);

    // Saturation at 2**CNT_W - 1, then clear.
    clear_req();
    for (int i = 0; i < 4; i++) begin
      issue(2'b10, 8'h7F, 8'h01, 1'b0);
      expect_rsp("sat", 8'h80, 1'b1, (i < 3) ? 32'(i + 1) : 32'h3);
    end
    clear_req();

    // Reset while a response is pending drops it.
    issue(2'b10, 8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    check("rr_valid_pre", 32'(bus.rsp_valid), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rr_valid", 32'(bus.rsp_valid), 32'h0);
    check("rr_acc", 32'(acc), 32'h0);
    check("rr_ovf", 32'(ovf_count), 32'h0);
    check("rr_ready", 32'(bus.req_ready), 32'h1);
    check("rr_result", 32'(bus.rsp_result), 32'h0);
    check("rr_alu_a", 32'(bus.alu_a), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Initiator-side controller for the team's 8-bit signed ALU (opcodes AND/OR/ADD/SUB, result plus overflow flag). It accepts operation requests over a valid/ready handshake, drives the ALU operand and opcode lines from registers, and captures the ALU result and overflow flag. It returns them on a valid/ready response channel. It also keeps an accumulator for chained operations and a saturating overflow-event counter.

## Interface
- BITS, 8, operand/result width, two's complement
- CNT_W, 8, width of the overflow-event counter
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 AND, 01 OR, 10 ADD, 11 SUB
- req_a  in  BITS  signed operand A, ignored when req_chain=1
- req_b  in  BITS  signed operand B
- req_chain  in  1  use the accumulator as operand A
- req_clr  in  1  clear-only request: zero the accumulator and counter, issue no ALU op, send no response
- alu_a, alu_b  out  BITS  registered operands to the ALU
- alu_f  out  2  registered opcode to the ALU
- alu_result  in  BITS  ALU combinational result
- alu_flag  in  1  ALU overflow/underflow flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  BITS  captured result
- rsp_flag  out  1  captured overflow flag
- acc  out  BITS  accumulator, equal to the last captured result
- ovf_count  out  CNT_W  saturating count of captured rsp_flag=1 events

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- Reset state is IDLE. On reset:
  - req_ready=1
  - rsp_valid=0
  - rsp_result=0, rsp_flag=0
  - acc=0, ovf_count=0
  - alu_a=0, alu_b=0, alu_f=00
- IDLE:
  - req_ready=1.
  - On req_valid with req_clr=1: acc and ovf_count become 0 and the FSM stays in IDLE. req_clr takes priority over any opcode on the same request.
  - On req_valid with req_clr=0: alu_a gets (req_chain ? acc : req_a), alu_b gets req_b, alu_f gets req_op. The FSM moves to EXEC.
- EXEC:
  - req_ready=0. This is a one-cycle settle for the combinational ALU.
  - At the end of the cycle: rsp_result gets alu_result and rsp_flag gets alu_flag.
  - acc gets alu_result.
  - ovf_count increments if alu_flag=1, saturating at all-ones. It never wraps.
  - The FSM moves to RESP.
- RESP:
  - rsp_valid=1 and req_ready=0.
  - rsp_result and rsp_flag hold stable until the handshake.
  - On rsp_ready the FSM returns to IDLE.
- alu_a, alu_b and alu_f hold their values between operations. They change only on request acceptance or reset.
- The sequencer does no arithmetic of its own. Flag semantics are the ALU's:
  - ADD overflows when both operands have the same sign and the result has a different sign.
  - SUB overflows when the operands have opposite signs and the result sign differs from A.
  - AND and OR always give flag=0.

## Timing
- Request accepted at edge N (req_valid & req_ready). ALU inputs become valid after edge N.
- Result captured at edge N+1. rsp_valid is high from after edge N+1.
- Minimum request-to-response latency is 2 cycles. Peak throughput is one op per 3 cycles.
- The response handshake completes at the first edge with rsp_valid & rsp_ready. req_ready is high from the following cycle.
- Back-pressure: rsp_ready=0 holds the FSM in RESP indefinitely. No request is accepted while waiting.
- A chained request accepted in the cycle right after RESP uses the updated acc. No hazard exists, because acc updates in EXEC.
- Reset asserted in any state overrides everything at that edge:
  - the FSM returns to IDLE;
  - all outputs take their reset values;
  - an in-flight response is dropped.
- A req_clr=1 request occupies one IDLE cycle. req_ready stays 1.

## Structure
- Shared package alu_pkg:
  - BITS
  - opcode enum alu_op_t: OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11
  - FSM enum seq_state_t: IDLE, EXEC, RESP
- One sub-module, sat_counter (parameter CNT_W; ports clk, reset, clr, inc, count). It is saturating and never wraps.
- The bench connects alu_a/alu_b/alu_f/alu_result/alu_flag to the existing ALU.

## Test plan
- ADD overflow: req_a=127, req_b=1, op=ADD. rsp_result=-128, rsp_flag=1, ovf_count=1, and rsp_valid is seen 2 cycles after acceptance.
- SUB underflow, then chain:
  - req_a=-128, req_b=1, op=SUB gives rsp_result=127, rsp_flag=1.
  - A chained ADD with req_b=1 then gives alu_a=127 and rsp_result=-128, flag=1, ovf_count=2.
- No overflow:
  - 127-1 gives 126, flag=0.
  - -128+1 gives -127, flag=0.
  - AND 8'hF0 with 8'h3C gives 8'h30. OR of the same operands gives 8'hFC. Both have flag=0 and ovf_count unchanged.
- Back-pressure: hold rsp_ready=0 for 5 cycles during a response.
  - rsp_result, rsp_flag and rsp_valid stay stable.
  - req_ready=0 throughout, and a pending req_valid is not accepted until the cycle after the handshake.
- Saturation and clear, with CNT_W=2:
  - 4 overflowing ADDs leave ovf_count=3.
  - A req_clr=1 request then sets ovf_count=0 and acc=0, with no rsp_valid pulse.
- Reset in RESP: assert reset with rsp_valid=1. After the edge, rsp_valid=0, acc=0, ovf_count=0, and the FSM is in IDLE with req_ready=1.
